// File: rtl/register_read_arbiter.sv
// Shares the register file's two synchronous read ports between decode lanes A and B.
// Slots 0..3 are A0, A1, B0, B1; a slot is issued, then captured on the following data cycle.
module register_read_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              a_req_i,
  input  logic              a_src0_vld_i,
  input  logic [ADDR_W-1:0] a_src0_addr_i,
  input  logic              a_src1_vld_i,
  input  logic [ADDR_W-1:0] a_src1_addr_i,
  input  logic              b_req_i,
  input  logic              b_src0_vld_i,
  input  logic [ADDR_W-1:0] b_src0_addr_i,
  input  logic              b_src1_vld_i,
  input  logic [ADDR_W-1:0] b_src1_addr_i,
  output logic [1:0]        rf_rd_en_o,
  output logic [ADDR_W-1:0] rf_rd_addr0_o,
  output logic [ADDR_W-1:0] rf_rd_addr1_o,
  input  logic [DATA_W-1:0] rf_rd_data0_i,
  input  logic [DATA_W-1:0] rf_rd_data1_i,
  output logic              a_done_o,
  output logic [DATA_W-1:0] a_op0_o,
  output logic [DATA_W-1:0] a_op1_o,
  output logic              a_busy_o,
  output logic              b_done_o,
  output logic [DATA_W-1:0] b_op0_o,
  output logic [DATA_W-1:0] b_op1_o,
  output logic              b_busy_o
);

  typedef enum logic {StIdle, StBusy} lane_st_e;

  lane_st_e          lane_q [2];
  lane_st_e          lane_d [2];
  logic [3:0]        need_q, need_d;
  logic [3:0]        iss1_q, iss1_d, iss2_q, iss2_d;
  logic [3:0]        psel1_q, psel1_d, psel2_q;
  logic [ADDR_W-1:0] addr_q [4];
  logic [ADDR_W-1:0] addr_d [4];
  logic [DATA_W-1:0] stg_q [4];
  logic [DATA_W-1:0] stg_d [4];
  logic [DATA_W-1:0] op_q [4];
  logic [DATA_W-1:0] op_d [4];
  logic [1:0]        done_q, done_d, en_q, en_d;
  logic [ADDR_W-1:0] raddr0_q, raddr0_d, raddr1_q, raddr1_d;
  logic              rr_q, rr_d;

  logic [1:0]        req;
  logic [3:0]        in_vld;
  logic [ADDR_W-1:0] in_addr [4];
  logic [1:0]        accept;
  logic [3:0]        elig, issue, psel, cap;
  logic [ADDR_W-1:0] eff_addr [4];
  logic [DATA_W-1:0] cdata [4];

  assign req        = {b_req_i, a_req_i};
  assign in_vld     = {b_src1_vld_i, b_src0_vld_i, a_src1_vld_i, a_src0_vld_i};
  assign in_addr[0] = a_src0_addr_i;
  assign in_addr[1] = a_src1_addr_i;
  assign in_addr[2] = b_src0_addr_i;
  assign in_addr[3] = b_src1_addr_i;

  // A request accepted this cycle is scheduled straight from the inputs so that the
  // address appears in the very next cycle.
  always_comb begin : issue_logic
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] p0, p1;
    logic [1:0]        s;
    cnt   = 2'd0;
    p0    = '0;
    p1    = '0;
    s     = 2'd0;
    issue = 4'b0;
    psel  = 4'b0;
    for (int l = 0; l < 2; l++) begin
      accept[l] = !flush_i && (lane_q[l] == StIdle) && req[l];
    end
    for (int i = 0; i < 4; i++) begin
      eff_addr[i] = accept[i>>1] ? in_addr[i] : addr_q[i];
      if (flush_i) begin
        elig[i] = 1'b0;
      end else if (accept[i>>1]) begin
        elig[i] = in_vld[i];
      end else begin
        elig[i] = (lane_q[i>>1] == StBusy) && need_q[i] && !iss1_q[i] && !iss2_q[i];
      end
    end
    for (int k = 0; k < 4; k++) begin
      s = 2'(k) ^ {rr_q, 1'b0};
      if (elig[s]) begin
        if (cnt != 2'd0 && eff_addr[s] == p0) begin
          issue[s] = 1'b1;
          psel[s]  = 1'b0;
        end else if (cnt == 2'd2 && eff_addr[s] == p1) begin
          issue[s] = 1'b1;
          psel[s]  = 1'b1;
        end else if (cnt == 2'd0) begin
          issue[s] = 1'b1;
          psel[s]  = 1'b0;
          p0       = eff_addr[s];
          cnt      = 2'd1;
        end else if (cnt == 2'd1) begin
          issue[s] = 1'b1;
          psel[s]  = 1'b1;
          p1       = eff_addr[s];
          cnt      = 2'd2;
        end
      end
    end
    en_d     = {cnt == 2'd2, cnt != 2'd0};
    raddr0_d = (cnt != 2'd0) ? p0 : raddr0_q;
    raddr1_d = (cnt == 2'd2) ? p1 : raddr1_q;
    rr_d     = rr_q ^ (rr_q ? |issue[3:2] : |issue[1:0]);
    iss1_d   = issue;
    psel1_d  = psel;
    iss2_d   = flush_i ? 4'b0 : iss1_q;
  end

  // Captured data is staged per slot; the visible operands change only on done.
  always_comb begin : lane_logic
    for (int i = 0; i < 4; i++) begin
      cap[i]   = iss2_q[i] && !flush_i;
      cdata[i] = psel2_q[i] ? rf_rd_data1_i : rf_rd_data0_i;
      addr_d[i] = accept[i>>1] ? in_addr[i] : addr_q[i];
      op_d[i]   = op_q[i];
      if (flush_i) begin
        need_d[i] = 1'b0;
      end else if (accept[i>>1]) begin
        need_d[i] = in_vld[i];
      end else begin
        need_d[i] = need_q[i] && !cap[i];
      end
      if (accept[i>>1]) begin
        stg_d[i] = op_q[i];
      end else if (cap[i]) begin
        stg_d[i] = cdata[i];
      end else begin
        stg_d[i] = stg_q[i];
      end
    end
    for (int l = 0; l < 2; l++) begin
      lane_d[l] = lane_q[l];
      done_d[l] = 1'b0;
      if (flush_i) begin
        lane_d[l] = StIdle;
      end else if (accept[l]) begin
        if (!in_vld[2*l] && !in_vld[2*l+1]) begin
          done_d[l] = 1'b1;
        end else begin
          lane_d[l] = StBusy;
        end
      end else if (lane_q[l] == StBusy && !need_d[2*l] && !need_d[2*l+1]) begin
        done_d[l]   = 1'b1;
        lane_d[l]   = StIdle;
        op_d[2*l]   = cap[2*l] ? cdata[2*l] : stg_q[2*l];
        op_d[2*l+1] = cap[2*l+1] ? cdata[2*l+1] : stg_q[2*l+1];
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      lane_q[0] <= StIdle;
      lane_q[1] <= StIdle;
      need_q    <= 4'b0;
      iss1_q    <= 4'b0;
      iss2_q    <= 4'b0;
      psel1_q   <= 4'b0;
      psel2_q   <= 4'b0;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= '0;
        stg_q[i]  <= '0;
        op_q[i]   <= '0;
      end
      done_q   <= 2'b0;
      en_q     <= 2'b0;
      raddr0_q <= '0;
      raddr1_q <= '0;
      rr_q     <= 1'b0;
    end else begin
      lane_q[0] <= lane_d[0];
      lane_q[1] <= lane_d[1];
      need_q    <= need_d;
      iss1_q    <= iss1_d;
      iss2_q    <= iss2_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel1_q;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= addr_d[i];
        stg_q[i]  <= stg_d[i];
        op_q[i]   <= op_d[i];
      end
      done_q   <= done_d;
      en_q     <= en_d;
      raddr0_q <= raddr0_d;
      raddr1_q <= raddr1_d;
      rr_q     <= rr_d;
    end
  end

  assign rf_rd_en_o    = en_q;
  assign rf_rd_addr0_o = raddr0_q;
  assign rf_rd_addr1_o = raddr1_q;
  assign a_done_o      = done_q[0];
  assign b_done_o      = done_q[1];
  assign a_op0_o       = op_q[0];
  assign a_op1_o       = op_q[1];
  assign b_op0_o       = op_q[2];
  assign b_op1_o       = op_q[3];
  assign a_busy_o      = (lane_q[0] == StBusy);
  assign b_busy_o      = (lane_q[1] == StBusy);

endmodule

// File: tb/tb_register_read_arbiter.sv
// Self-checking bench for register_read_arbiter: directed scenarios plus random two-lane
// traffic checked against a per-lane scoreboard of expected operand pairs.
module tb_register_read_arbiter;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, flush;
  logic          a_req, a_v0, a_v1, b_req, b_v0, b_v1;
  logic [AW-1:0] a_a0, a_a1, b_a0, b_a1;
  logic [1:0]    en;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;
  logic          a_done, b_done, a_busy, b_busy;
  logic [DW-1:0] a_op0, a_op1, b_op0, b_op1;

  logic [DW-1:0]   rf [16];
  logic [2*DW-1:0] sbq_a [$];
  logic [2*DW-1:0] sbq_b [$];
  logic [2*DW-1:0] exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  register_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_i(clk), .reset_i(rst_n), .flush_i(flush),
    .a_req_i(a_req), .a_src0_vld_i(a_v0), .a_src0_addr_i(a_a0),
    .a_src1_vld_i(a_v1), .a_src1_addr_i(a_a1),
    .b_req_i(b_req), .b_src0_vld_i(b_v0), .b_src0_addr_i(b_a0),
    .b_src1_vld_i(b_v1), .b_src1_addr_i(b_a1),
    .rf_rd_en_o(en), .rf_rd_addr0_o(ra0), .rf_rd_addr1_o(ra1),
    .rf_rd_data0_i(rd0), .rf_rd_data1_i(rd1),
    .a_done_o(a_done), .a_op0_o(a_op0), .a_op1_o(a_op1), .a_busy_o(a_busy),
    .b_done_o(b_done), .b_op0_o(b_op0), .b_op1_o(b_op1), .b_busy_o(b_busy)
  );

  always #5 clk = ~clk;

  // Synchronous register file; garbage on ports that were not enabled.
  always_ff @(posedge clk) begin
    rd0 <= en[0] ? rf[ra0] : $urandom();
    rd1 <= en[1] ? rf[ra1] : $urandom();
  end

  task automatic drive_idle();
    a_req = 0; a_v0 = 0; a_v1 = 0; a_a0 = '0; a_a1 = '0;
    b_req = 0; b_v0 = 0; b_v1 = 0; b_a0 = '0; b_a1 = '0;
    flush = 0;
  endtask

  task automatic drive_a(input logic v0, input logic [AW-1:0] r0,
                         input logic v1, input logic [AW-1:0] r1);
    a_req = 1; a_v0 = v0; a_a0 = r0; a_v1 = v1; a_a1 = r1;
  endtask

  task automatic drive_b(input logic v0, input logic [AW-1:0] r0,
                         input logic v1, input logic [AW-1:0] r1);
    b_req = 1; b_v0 = v0; b_a0 = r0; b_v1 = v1; b_a1 = r1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    sbq_a.delete();
    sbq_b.delete();
  endtask

  task automatic test_reset();
    drive_idle();
    drive_a(1, 4'd3, 1, 4'd5);
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({en, ra0, ra1, a_done, b_done, a_busy, b_busy} !== '0) begin
      n_bad++; $display("FAIL rst_ctrl act=%b req=0", {en, ra0, ra1, a_done, b_done, a_busy, b_busy});
    end
    n_cmp++;
    if ({a_op0, a_op1, b_op0, b_op1} !== '0) begin
      n_bad++; $display("FAIL rst_ops act=%h req=0", {a_op0, a_op1, b_op0, b_op1});
    end
    drive_idle();
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if ({en, a_done, b_done, a_busy, b_busy} !== '0) begin
      n_bad++; $display("FAIL rst_release act=%b req=0", {en, a_done, b_done, a_busy, b_busy});
    end
  endtask

  task automatic test_single();
    do_reset();
    drive_a(1, 4'd3, 1, 4'd5);
    sbq_a.push_back({rf[5], rf[3]});
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if ({en, ra0, ra1, a_busy, a_done} !== {2'b11, 4'd3, 4'd5, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL t1_c1 act=%b req=%b", {en, ra0, ra1, a_busy, a_done},
                        {2'b11, 4'd3, 4'd5, 1'b1, 1'b0});
    end
    @(negedge clk);
    n_cmp++;
    if ({en, a_busy, a_done} !== 4'b0010) begin
      n_bad++; $display("FAIL t1_c2 act=%b req=0010", {en, a_busy, a_done});
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, a_busy} !== 2'b10) begin
      n_bad++; $display("FAIL t1_done act=%b req=10", {a_done, a_busy});
    end
    exp_v = sbq_a.pop_front();
    n_cmp++;
    if ({a_op1, a_op0} !== exp_v) begin
      n_bad++; $display("FAIL t1_ops act=%h req=%h", {a_op1, a_op0}, exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b0) begin
      n_bad++; $display("FAIL t1_pulse act=%b req=0", a_done);
    end
  endtask

  task automatic test_contention();
    do_reset();
    drive_a(1, 4'd1, 1, 4'd2);
    drive_b(1, 4'd6, 1, 4'd7);
    sbq_a.push_back({rf[2], rf[1]});
    sbq_b.push_back({rf[7], rf[6]});
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if ({en, ra0, ra1, a_busy, b_busy} !== {2'b11, 4'd1, 4'd2, 2'b11}) begin
      n_bad++; $display("FAIL t2_c1 act=%b", {en, ra0, ra1, a_busy, b_busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({en, ra0, ra1} !== {2'b11, 4'd6, 4'd7}) begin
      n_bad++; $display("FAIL t2_c2 act=%b req=%b", {en, ra0, ra1}, {2'b11, 4'd6, 4'd7});
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, b_done, b_busy} !== 3'b101) begin
      n_bad++; $display("FAIL t2_c3 act=%b req=101", {a_done, b_done, b_busy});
    end
    exp_v = sbq_a.pop_front();
    n_cmp++;
    if ({a_op1, a_op0} !== exp_v) begin
      n_bad++; $display("FAIL t2_a_ops act=%h req=%h", {a_op1, a_op0}, exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, b_done} !== 2'b01) begin
      n_bad++; $display("FAIL t2_c4 act=%b req=01", {a_done, b_done});
    end
    exp_v = sbq_b.pop_front();
    n_cmp++;
    if ({b_op1, b_op0} !== exp_v) begin
      n_bad++; $display("FAIL t2_b_ops act=%h req=%h", {b_op1, b_op0}, exp_v);
    end
  endtask

  task automatic test_dedup();
    do_reset();
    drive_a(1, 4'd4, 1, 4'd4);
    drive_b(1, 4'd4, 1, 4'd9);
    sbq_a.push_back({rf[4], rf[4]});
    sbq_b.push_back({rf[9], rf[4]});
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if ({en, ra0, ra1} !== {2'b11, 4'd4, 4'd9}) begin
      n_bad++; $display("FAIL t3_c1 act=%b req=%b", {en, ra0, ra1}, {2'b11, 4'd4, 4'd9});
    end
    @(negedge clk);
    n_cmp++;
    if (en !== 2'b00) begin
      n_bad++; $display("FAIL t3_c2 act=%b req=00", en);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, b_done} !== 2'b11) begin
      n_bad++; $display("FAIL t3_done act=%b req=11", {a_done, b_done});
    end
    exp_v = sbq_a.pop_front();
    n_cmp++;
    if ({a_op1, a_op0} !== exp_v) begin
      n_bad++; $display("FAIL t3_a_ops act=%h req=%h", {a_op1, a_op0}, exp_v);
    end
    exp_v = sbq_b.pop_front();
    n_cmp++;
    if ({b_op1, b_op0} !== exp_v) begin
      n_bad++; $display("FAIL t3_b_ops act=%h req=%h", {b_op1, b_op0}, exp_v);
    end
  endtask

  task automatic test_back_to_back_nosrc();
    do_reset();
    drive_a(1, 4'd2, 1, 4'd3);
    sbq_a.push_back({rf[3], rf[2]});
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_done !== 1'b1) begin
      n_bad++; $display("FAIL t4_first_done act=%b req=1", a_done);
    end
    exp_v = sbq_a.pop_front();
    // Request with no sources issued in the done cycle.
    drive_a(0, 4'd7, 0, 4'd8);
    sbq_a.push_back(exp_v);
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if ({a_done, a_busy, en} !== 4'b1000) begin
      n_bad++; $display("FAIL t4_nosrc act=%b req=1000", {a_done, a_busy, en});
    end
    exp_v = sbq_a.pop_front();
    n_cmp++;
    if ({a_op1, a_op0} !== exp_v) begin
      n_bad++; $display("FAIL t4_ops act=%h req=%h", {a_op1, a_op0}, exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, en} !== 3'b000) begin
      n_bad++; $display("FAIL t4_after act=%b req=000", {a_done, en});
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive_a(1, 4'd3, 1, 4'd5);
    sbq_a.push_back({rf[5], rf[3]});
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    exp_v = sbq_a.pop_front();
    n_cmp++;
    if ({a_done, a_op1, a_op0} !== {1'b1, exp_v}) begin
      n_bad++; $display("FAIL t5_pre act=%h req=%h", {a_done, a_op1, a_op0}, {1'b1, exp_v});
    end
    drive_a(1, 4'd1, 1, 4'd2);
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if ({en, ra0, ra1, a_busy} !== {2'b11, 4'd1, 4'd2, 1'b1}) begin
      n_bad++; $display("FAIL t5_c1 act=%b", {en, ra0, ra1, a_busy});
    end
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    n_cmp++;
    if ({a_done, a_busy, en} !== 4'b0000) begin
      n_bad++; $display("FAIL t5_flushed act=%b req=0000", {a_done, a_busy, en});
    end
    n_cmp++;
    if ({a_op1, a_op0} !== exp_v) begin
      n_bad++; $display("FAIL t5_ops_kept act=%h req=%h", {a_op1, a_op0}, exp_v);
    end
    drive_a(1, 4'd6, 1, 4'd7);
    sbq_a.push_back({rf[7], rf[6]});
    @(negedge clk);
    drive_idle();
    n_cmp++;
    if ({a_done, en, ra0, ra1} !== {1'b0, 2'b11, 4'd6, 4'd7}) begin
      n_bad++; $display("FAIL t5_new_c1 act=%b", {a_done, en, ra0, ra1});
    end
    @(negedge clk);
    @(negedge clk);
    exp_v = sbq_a.pop_front();
    n_cmp++;
    if ({a_done, a_op1, a_op0} !== {1'b1, exp_v}) begin
      n_bad++; $display("FAIL t5_new_done act=%h req=%h", {a_done, a_op1, a_op0}, {1'b1, exp_v});
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    drive_a(1, 4'd3, 1, 4'd5);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({en, ra0, ra1, a_done, a_busy, a_op0, a_op1} !== '0) begin
      n_bad++; $display("FAIL t6_async act=%h req=0", {en, ra0, ra1, a_done, a_busy, a_op0, a_op1});
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_done, a_busy, en} !== 4'b0000) begin
        n_bad++; $display("FAIL t6_post c=%0d act=%b req=0000", c, {a_done, a_busy, en});
      end
    end
  endtask

  task automatic test_random(input int ncyc);
    bit            pend [2];
    bit            hassrc [2];
    int            age [2];
    logic [DW-1:0] l0 [2];
    logic [DW-1:0] l1 [2];
    logic [DW-1:0] o0 [2];
    logic [DW-1:0] o1 [2];
    logic [1:0]    dn, bz;
    logic          v0, v1;
    logic [AW-1:0] r0, r1;
    logic [2*DW-1:0] e;
    bit            fprev;
    do_reset();
    fprev = 0;
    for (int l = 0; l < 2; l++) begin
      pend[l] = 0; hassrc[l] = 0; age[l] = 0; l0[l] = '0; l1[l] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      dn = {b_done, a_done};
      bz = {b_busy, a_busy};
      o0[0] = a_op0; o1[0] = a_op1; o0[1] = b_op0; o1[1] = b_op1;
      if (fprev) begin
        n_cmp++;
        if ({en, dn} !== 4'b0000) begin
          n_bad++; $display("FAIL rnd_flush c=%0d act=%b req=0000", c, {en, dn});
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (dn[l]) begin
          n_cmp++;
          if (!pend[l]) begin
            n_bad++; $display("FAIL rnd_done c=%0d lane=%0d act=1 req=0", c, l);
          end else begin
            e = (l == 0) ? sbq_a.pop_front() : sbq_b.pop_front();
            {l1[l], l0[l]} = e;
            pend[l] = 0;
          end
        end else if (pend[l]) begin
          age[l]++;
          if (age[l] > 12) begin
            n_cmp++; n_bad++;
            $display("FAIL rnd_timeout c=%0d lane=%0d act=no_done req=done", c, l);
            pend[l] = 0;
            if (l == 0) sbq_a.delete(); else sbq_b.delete();
          end
        end
        n_cmp++;
        if ({o1[l], o0[l]} !== {l1[l], l0[l]}) begin
          n_bad++; $display("FAIL rnd_ops c=%0d lane=%0d act=%h req=%h", c, l,
                            {o1[l], o0[l]}, {l1[l], l0[l]});
        end
        n_cmp++;
        if (bz[l] !== (pend[l] & hassrc[l])) begin
          n_bad++; $display("FAIL rnd_busy c=%0d lane=%0d act=%b req=%b", c, l, bz[l],
                            pend[l] & hassrc[l]);
        end
      end
      drive_idle();
      flush = ($urandom_range(63) == 0);
      for (int l = 0; l < 2; l++) begin
        if ($urandom_range(3) != 0) begin
          v0 = 1'($urandom_range(1));
          v1 = 1'($urandom_range(1));
          r0 = 4'($urandom_range(15));
          r1 = 4'($urandom_range(15));
          if (l == 0) drive_a(v0, r0, v1, r1); else drive_b(v0, r0, v1, r1);
          if (!flush && !pend[l]) begin
            pend[l] = 1; hassrc[l] = v0 | v1; age[l] = 0;
            e = {v1 ? rf[r1] : l1[l], v0 ? rf[r0] : l0[l]};
            if (l == 0) sbq_a.push_back(e); else sbq_b.push_back(e);
          end
        end
      end
      if (flush) begin
        pend[0] = 0; pend[1] = 0;
        sbq_a.delete(); sbq_b.delete();
      end
      fprev = flush;
    end
    drive_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = $urandom() ^ i;
    rst_n = 0;
    drive_idle();
    test_reset();
    test_single();
    test_contention();
    test_dedup();
    test_back_to_back_nosrc();
    test_flush();
    test_reset_midop();
    test_random(10000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
